mac_pipe: RTL and testbench

MAC_PIPE -- requirements
Module: mac_pipe

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_mul_stage.sv | 38 +++
 rtl/mac_pipe.sv | 89 ++++++++
 tb/tb_mac_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the mac_pipe multiply-accumulate block:
// default widths and the FSM state encoding exported on the state port.
package mac_pkg;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_ACC_W = 16;
    localparam int DEF_CNT_W = 8;

    // Encoding is visible on the state output, so values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // nothing accumulated since the last clear
        ST_ACC  = 2'd1,   // accumulating without carry
        ST_OVF  = 2'd2    // accumulator carried out; result frozen
    } state_t;

endpackage

// File: rtl/mac_mul_stage.sv
// Stage 1 of mac_pipe: registers the unsigned product of one operand
// pair together with its valid bit. A flush drops the held product.
module mac_mul_stage
    import mac_pkg::*;
#(
    parameter int IN_W = DEF_IN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic [IN_W-1:0]   op_a,
    input  logic [IN_W-1:0]   op_b,
    output logic [2*IN_W-1:0] product,
    output logic              valid
);

    // Valid bit: set on an accepted pair, dropped by reset or flush.
    // NOTE: state registers use non-blocking (<=) so every flop samples its
    // inputs from before the edge; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= 1'b0;
        end else begin
            valid <= load;
        end
    end

    // Product register: loaded only on an accepted pair.
    // NOTE: datapath register deliberately has no reset; the valid bit alone
    // qualifies it, which keeps the reset net off the multiplier outputs.
    always_ff @(posedge clk) begin
        if (load) begin
            product <= {{IN_W{1'b0}}, op_a} * {{IN_W{1'b0}}, op_b};
        end
    end

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: two-stage unsigned multiply-accumulate.
//   stage 1 (mac_mul_stage) registers op_a*op_b on a handshake,
//   stage 2 adds the product into the accumulator, tracks a saturating
//   accumulation count and a sticky overflow flag.
// Build option: define MAC_SATURATE_EN to load all-ones into the
// accumulator on overflow instead of zero.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,   // must be >= 2*IN_W
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  op_a,
    input  logic [IN_W-1:0]  op_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    input  logic             hold,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    output logic             overflow,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state
);

`ifdef MAC_SATURATE_EN
    localparam logic [ACC_W-1:0] OVF_LOAD = '1;
`else
    localparam logic [ACC_W-1:0] OVF_LOAD = '0;
`endif

    logic [2*IN_W-1:0] s1_product;
    logic              s1_valid;
    logic              accept;
    logic [ACC_W:0]    sum;
    state_t            state_q;

    // clr and hold both refuse new pairs; reset does too.
    assign in_ready = ~rst & ~clr & ~hold;
    assign accept   = in_valid & in_ready;

    mac_mul_stage #(
        .IN_W (IN_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .flush   (clr),
        .op_a    (op_a),
        .op_b    (op_b),
        .product (s1_product),
        .valid   (s1_valid)
    );

    // One extra bit above the accumulator catches the carry-out.
    assign sum   = {1'b0, acc_out} + {{(ACC_W + 1 - 2*IN_W){1'b0}}, s1_product};
    assign state = state_q;

    // Stage 2: accumulate, count, detect overflow and step the FSM.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_out   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
            state_q   <= ST_IDLE;
        end else begin
            out_valid <= 1'b0;
            if (s1_valid && state_q != ST_OVF) begin
                out_valid <= 1'b1;
                if (count != '1) begin
                    count <= count + CNT_W'(1);
                end
                if (sum[ACC_W]) begin
                    acc_out  <= OVF_LOAD;
                    overflow <= 1'b1;
                    state_q  <= ST_OVF;
                end else begin
                    acc_out  <= sum[ACC_W-1:0];
                    state_q  <= ST_ACC;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// Self-checking bench for mac_pipe (IN_W=8, ACC_W=16, CNT_W=8).
// A queue-based reference model tracks products in flight and applies
// the accumulate/overflow/count rules with plain integer arithmetic.
module tb_mac_pipe;

    localparam int IN_W    = 8;
    localparam int ACC_W   = 16;
    localparam int CNT_W   = 8;
    localparam int ACC_MAX = (1 << ACC_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef MAC_SATURATE_EN
    localparam int OVF_VAL = ACC_MAX;
`else
    localparam int OVF_VAL = 0;
`endif

    logic             clk = 1'b0;
    logic             rst, clr, hold, in_valid;
    logic [IN_W-1:0]  op_a, op_b;
    logic             in_ready, out_valid, overflow;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] count;
    logic [1:0]       state;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    typedef struct { int due; int prod; } pend_t;
    pend_t q[$];
    int    edge_n = 0;
    int    m_acc  = 0;
    int    m_cnt  = 0;
    bit    m_ovf  = 0;
    bit    m_any  = 0;
    bit    m_ov   = 0;

    mac_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_a      (op_a),
        .op_b      (op_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clr       (clr),
        .hold      (hold),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .overflow  (overflow),
        .count     (count),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit c, input bit h, input bit v,
                         input int a, input int b);
        rst      = r;
        clr      = c;
        hold     = h;
        in_valid = v;
        op_a     = IN_W'(a);
        op_b     = IN_W'(b);
    endtask

    // Apply one completed product to the abstract accumulator.
    task automatic apply(input int p);
        if (m_ovf) return;
        m_ov  = 1;
        m_any = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
        if (m_acc + p > ACC_MAX) begin
            m_ovf = 1;
            m_acc = OVF_VAL;
        end else begin
            m_acc = m_acc + p;
        end
    endtask

    // Advance the model by one rising edge using the inputs held across it.
    task automatic model_edge();
        pend_t e;
        edge_n++;
        m_ov = 0;
        if (rst || clr) begin
            q.delete();
            m_acc = 0;
            m_cnt = 0;
            m_ovf = 0;
            m_any = 0;
        end else begin
            if (q.size() > 0 && q[0].due == edge_n) begin
                e = q.pop_front();
                apply(e.prod);
            end
            if (in_valid && !hold) q.push_back('{edge_n + 1, int'(op_a) * int'(op_b)});
        end
    endtask

    // Check in_ready for the current inputs, clock once, check registered outputs.
    task automatic tick(input string tag);
        int exp_state;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!rst && !clr && !hold));
        @(posedge clk);
        model_edge();
        #1;
        exp_state = m_ovf ? 2 : (m_any ? 1 : 0);
        chk({tag, ".acc_out"},   32'(acc_out),   32'(m_acc));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, ".count"},     32'(count),     32'(m_cnt));
        chk({tag, ".state"},     32'(state),     32'(exp_state));
    endtask

    initial begin
        int r;
        bit rr, cc, hh, vv;
        int a, b;

        // Reset
        drive(1, 0, 0, 0, 0, 0);
        tick("reset0");
        tick("reset1");

        // 3*4: result two edges after the handshake
        drive(0, 0, 0, 1, 3, 4);
        tick("basic_hs");
        drive(0, 0, 0, 0, 0, 0);
        tick("basic_s1");
        chk("basic.acc12", 32'(acc_out), 32'd12);
        chk("basic.pulse", 32'(out_valid), 32'd1);
        tick("basic_after");

        // Overflow boundary: 0xFE01, 0xFFFF, then carry
        drive(0, 1, 0, 0, 0, 0);
        tick("ovf_clr");
        drive(0, 0, 0, 1, 255, 255);
        tick("ovf_a");
        drive(0, 0, 0, 1, 255, 2);
        tick("ovf_b");
        chk("ovf.fe01", 32'(acc_out), 32'h0000fe01);
        drive(0, 0, 0, 1, 1, 1);
        tick("ovf_c");
        chk("ovf.ffff", 32'(acc_out), 32'h0000ffff);
        chk("ovf.noflag", 32'(overflow), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        tick("ovf_d");
        chk("ovf.flag", 32'(overflow), 32'd1);
        chk("ovf.state", 32'(state), 32'd2);
        chk("ovf.acc", 32'(acc_out), 32'(OVF_VAL));
        tick("ovf_e");

        // In OVF: pairs accepted but nothing changes; clr recovers
        drive(0, 0, 0, 1, 5, 5);
        tick("inovf_offer");
        drive(0, 0, 0, 0, 0, 0);
        tick("inovf_w1");
        tick("inovf_w2");
        drive(0, 1, 0, 0, 0, 0);
        tick("inovf_clr");

        // clr with in_valid: clr wins
        drive(0, 0, 0, 1, 2, 3);
        tick("clrv_pre");
        drive(0, 1, 0, 1, 7, 7);
        tick("clrv_clr");
        drive(0, 0, 0, 0, 0, 0);
        tick("clrv_w1");
        tick("clrv_w2");
        tick("clrv_w3");

        // Reset with a product in flight
        drive(0, 0, 0, 1, 2, 3);
        tick("rstf_pre");
        drive(0, 0, 0, 1, 10, 10);
        tick("rstf_hs");
        drive(1, 0, 0, 0, 0, 0);
        tick("rstf_rst");
        drive(0, 0, 0, 0, 0, 0);
        tick("rstf_w1");
        tick("rstf_w2");
        tick("rstf_w3");

        // hold for 4 cycles, then release for one accumulation
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 1, 9, 9);
            tick("hold_on");
        end
        drive(0, 0, 0, 1, 9, 9);
        tick("hold_rel");
        drive(0, 0, 0, 0, 0, 0);
        tick("hold_w1");
        tick("hold_w2");
        chk("hold.one_acc", 32'(count), 32'd1);

        // Count saturation with zero products
        drive(0, 1, 0, 0, 0, 0);
        tick("sat_clr");
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            tick("sat_run");
        end
        drive(0, 0, 0, 0, 0, 0);
        tick("sat_w1");
        tick("sat_w2");
        chk("sat.count", 32'(count), 32'(CNT_MAX));

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            r  = $urandom_range(0, 99);
            rr = (r < 2);
            cc = (r >= 2 && r < 10);
            hh = ($urandom_range(0, 99) < 20);
            vv = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
            end else begin
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
            end
            drive(rr, cc, hh, vv, a, b);
            tick("rand");
        end
        drive(0, 0, 0, 0, 0, 0);
        tick("rand_w1");
        tick("rand_w2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
